// File: rtl/race_runner.sv
// Responder side of the ready/start/done race handshake: accepts a start,
// runs a programmable-length race, reports done/abort, then cools down.
module race_runner #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned RACE_W   = 4,
  parameter int unsigned COOL_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic [CNT_W-1:0]  run_len,
  output logic              ready,
  output logic              done,
  output logic              aborted,
  output logic [CNT_W-1:0]  elapsed,
  output logic [RACE_W-1:0] race_count
);

  localparam int unsigned COOL_W = (COOL_CYC < 1) ? 1 : $clog2(COOL_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2,
    S_COOL   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                aborted_q, aborted_d;
  logic [CNT_W-1:0]    elapsed_q, elapsed_d;
  logic [RACE_W-1:0]   race_count_q, race_count_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    target_q, target_d;
  logic [COOL_W-1:0]   cool_q, cool_d;

  logic accept_c;
  logic last_c;

  assign accept_c = ready_q && start;
  assign last_c   = (cnt_q == (target_q - CNT_W'(1)));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a dropped start in RUN wins over completion
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = accept_c ? S_RUN : S_IDLE;
      S_RUN: begin
        if (!start)      state_d = S_COOL;
        else if (last_c) state_d = S_FINISH;
        else             state_d = S_RUN;
      end
      S_FINISH: state_d = start ? S_FINISH : S_COOL;
      S_COOL:   state_d = (cool_q == '0) ? S_IDLE : S_COOL;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    ready_d      = 1'b0;
    done_d       = 1'b0;
    aborted_d    = 1'b0;
    elapsed_d    = elapsed_q;
    race_count_d = race_count_q;
    cnt_d        = cnt_q;
    target_d     = target_q;
    cool_d       = cool_q;
    case (state_q)
      S_IDLE: begin
        ready_d = enable;
        if (accept_c) begin
          ready_d  = 1'b0;
          cnt_d    = '0;
          target_d = (run_len == '0) ? CNT_W'(1) : run_len;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!start) begin
          aborted_d = 1'b1;
          cool_d    = COOL_W'(COOL_CYC);
        end else if (last_c) begin
          done_d       = 1'b1;
          elapsed_d    = target_q;
          race_count_d = (race_count_q == '1) ? race_count_q
                                              : race_count_q + RACE_W'(1);
        end
      end
      S_FINISH: begin
        done_d = start;
        if (!start) cool_d = COOL_W'(COOL_CYC);
      end
      S_COOL: begin
        if (cool_q != '0) cool_d = cool_q - COOL_W'(1);
      end
      default: begin
        cnt_d    = '0;
        target_d = '0;
        cool_d   = '0;
      end
    endcase
  end

  // Registered outputs and internal counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      elapsed_q    <= '0;
      race_count_q <= '0;
      cnt_q        <= '0;
      target_q     <= '0;
      cool_q       <= '0;
    end else begin
      ready_q      <= ready_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      elapsed_q    <= elapsed_d;
      race_count_q <= race_count_d;
      cnt_q        <= cnt_d;
      target_q     <= target_d;
      cool_q       <= cool_d;
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign elapsed    = elapsed_q;
  assign race_count = race_count_q;

endmodule
